// File: rtl/byte_to_dibit_fifo.sv
// Width-down-converting FIFO: stores whole bytes and returns them as 2-bit symbols,
// least-significant dibit first, one per accepted read.
module byte_to_dibit_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      write,
    input  logic [7:0]                din,
    input  logic                      read,
    output logic [1:0]                dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(4*DEPTH):0]  level,
    output logic                      ovf,
    output logic                      udf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(4*DEPTH) + 1;
    localparam logic [LW-1:0] FullLevel = LW'(4*DEPTH - 4);

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW+2:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;
    logic [7:0]    rd_byte;
    logic [1:0]    rd_dibit;

    assign empty      = (level_q == '0);
    assign full       = (level_q > FullLevel);
    assign level      = level_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

    // Upper read-pointer bits pick the byte, low two bits pick the dibit within it.
    assign rd_byte  = mem[rd_ptr_q[AW+1:2]];
    assign rd_dibit = rd_byte[{rd_ptr_q[1:0], 1'b0} +: 2];

    always_comb begin
        wr_acc       = write && !full;
        rd_acc       = read && !empty;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d     = rd_ptr_q + {{(AW+2){1'b0}}, rd_acc};
        level_d      = level_q;
        if (wr_acc) begin
            level_d = level_d + LW'(4);
        end
        if (rd_acc) begin
            level_d = level_d - LW'(1);
        end
        dout_d       = rd_acc ? rd_dibit : dout_q;
        dout_valid_d = rd_acc;
        ovf_d        = write && full;
        udf_d        = read && empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Distance between the pointers, in dibits, must always equal the level counter.
    assert property (@(posedge clk) disable iff (!reset_n)
        level_q == ({wr_ptr_q, 2'b00} - rd_ptr_q));

endmodule
